// File: rtl/stream_fifo_rd_bridge.sv
// Valid/ready stream sink presented as a non-FWFT FIFO read port (rd_en, registered data, empty).
// Storage is a 2**AW x DW array written on accepted beats and read into a registered output on pops.
module stream_fifo_rd_bridge #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] stream_s_data_i,
    input  logic          stream_s_valid_i,
    output logic          stream_s_ready_o,
    input  logic          fifo_rd_en_i,
    output logic [DW-1:0] fifo_data_o,
    output logic          fifo_empty_o,
    output logic [AW:0]   fifo_level_o,
    output logic          fifo_underflow_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   wr_ptr_next;
    logic [AW:0]   rd_ptr_reg;
    logic [AW:0]   rd_ptr_next;
    logic [DW-1:0] data_reg;
    logic          ready_reg;
    logic          ready_next;
    logic          underflow_reg;
    logic          underflow_next;
    logic          empty;
    logic          push;
    logic          pop;

    always_comb begin
        empty          = (wr_ptr_reg == rd_ptr_reg);
        push           = stream_s_valid_i && ready_reg;
        pop            = fifo_rd_en_i && !empty;
        wr_ptr_next    = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next    = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        // Ready tracks the pointers it will see next cycle, so it is never
        // high while full and rises the cycle after a pop frees a slot.
        ready_next     = !((wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                           (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]));
        underflow_next = underflow_reg || (fifo_rd_en_i && empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            data_reg      <= '0;
            ready_reg     <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            ready_reg     <= ready_next;
            underflow_reg <= underflow_next;
            if (pop) begin
                data_reg <= mem[rd_ptr_reg[AW-1:0]];
            end
        end
    end

    // Contents are deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= stream_s_data_i;
        end
    end

    assign stream_s_ready_o = ready_reg;
    assign fifo_data_o      = data_reg;
    assign fifo_empty_o     = empty;
    assign fifo_level_o     = wr_ptr_reg - rd_ptr_reg;
    assign fifo_underflow_o = underflow_reg;

endmodule

// File: tb/tb_stream_fifo_rd_bridge.sv
// Directed bench for stream_fifo_rd_bridge: reset, ordering, full, wrap, empty boundary, async reset.
module tb_stream_fifo_rd_bridge;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          rd_en;
    logic [DW-1:0] f_data;
    logic          f_empty;
    logic [AW:0]   f_level;
    logic          f_underflow;

    int tests = 0;
    int fails = 0;

    stream_fifo_rd_bridge #(.DW(DW), .AW(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stream_s_data_i  (s_data),
        .stream_s_valid_i (s_valid),
        .stream_s_ready_o (s_ready),
        .fifo_rd_en_i     (rd_en),
        .fifo_data_o      (f_data),
        .fifo_empty_o     (f_empty),
        .fifo_level_o     (f_level),
        .fifo_underflow_o (f_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset across one edge, release mid-cycle, then wait for ready.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        s_data  = 8'h11;
        s_valid = 1'b1;
        rd_en   = 1'b1;

        // 1. Reset sequencing
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_ready", 32'(s_ready), 32'd0);
            check("rst_empty", 32'(f_empty), 32'd1);
        end
        check("rst_level", 32'(f_level), 32'd0);
        check("rst_data", 32'(f_data), 32'd0);
        check("rst_underflow", 32'(f_underflow), 32'd0);
        s_valid = 1'b0;
        rd_en   = 1'b0;
        rst_n   = 1'b1;
        #1;
        check("post_rst_ready_c1", 32'(s_ready), 32'd0);
        check("post_rst_empty_c1", 32'(f_empty), 32'd1);
        tick();
        check("post_rst_ready_c2", 32'(s_ready), 32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("first_pop_underflow", 32'(f_underflow), 32'd1);
        check("first_pop_data", 32'(f_data), 32'd0);
        check("first_pop_empty", 32'(f_empty), 32'd1);

        // 2. Ordered transfer
        for (int i = 0; i < 5; i++) begin
            s_data  = 8'(i + 1);
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        check("ord_level", 32'(f_level), 32'd5);
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("ord_data%0d", i), 32'(f_data), 32'(i + 1));
        end
        rd_en = 1'b0;
        check("ord_empty", 32'(f_empty), 32'd1);
        check("ord_level_end", 32'(f_level), 32'd0);

        // 3. Fill to full
        for (int i = 0; i < 16; i++) begin
            s_data  = 8'(8'h40 + i);
            s_valid = 1'b1;
            tick();
        end
        check("full_level", 32'(f_level), 32'd16);
        check("full_ready", 32'(s_ready), 32'd0);
        s_data = 8'h77;
        tick();
        check("full_pending_level", 32'(f_level), 32'd16);
        check("full_pending_ready", 32'(s_ready), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("full_pop_data", 32'(f_data), 32'h40);
        check("full_pop_level", 32'(f_level), 32'd15);
        check("full_pop_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        check("full_refill_level", 32'(f_level), 32'd16);
        check("full_refill_ready", 32'(s_ready), 32'd0);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("full_drain%0d", i), 32'(f_data),
                  (i == 15) ? 32'h77 : 32'(8'h41 + i));
        end
        rd_en = 1'b0;
        check("full_drain_empty", 32'(f_empty), 32'd1);

        // 4. Concurrent streaming and wrap
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_data  = 8'(8'hF0 + i);
            s_valid = 1'b1;
            tick();
        end
        check("conc_preload_level", 32'(f_level), 32'd3);
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_data = 8'(i);
            tick();
            check($sformatf("conc_level%0d", i), 32'(f_level), 32'd3);
            check($sformatf("conc_data%0d", i), 32'(f_data),
                  (i < 3) ? 32'(8'hF0 + i) : 32'(i - 3));
        end
        s_valid = 1'b0;
        for (int i = 37; i < 40; i++) begin
            tick();
            check($sformatf("conc_tail%0d", i), 32'(f_data), 32'(i));
        end
        rd_en = 1'b0;
        check("conc_empty", 32'(f_empty), 32'd1);
        check("conc_underflow", 32'(f_underflow), 32'd0);

        // 5. Empty boundary: write plus pop while empty
        s_data  = 8'hA5;
        s_valid = 1'b1;
        rd_en   = 1'b1;
        tick();
        s_valid = 1'b0;
        check("eb_underflow", 32'(f_underflow), 32'd1);
        check("eb_data_held", 32'(f_data), 32'h27);
        check("eb_empty", 32'(f_empty), 32'd0);
        check("eb_level", 32'(f_level), 32'd1);
        tick();
        rd_en = 1'b0;
        check("eb_pop_data", 32'(f_data), 32'hA5);
        check("eb_pop_empty", 32'(f_empty), 32'd1);

        // 6. Mid-operation asynchronous reset
        for (int i = 0; i < 7; i++) begin
            s_data  = 8'(8'hC0 + i);
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        check("mid_level_pre", 32'(f_level), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_empty", 32'(f_empty), 32'd1);
        check("mid_level", 32'(f_level), 32'd0);
        check("mid_data", 32'(f_data), 32'd0);
        check("mid_ready", 32'(s_ready), 32'd0);
        check("mid_underflow", 32'(f_underflow), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("mid_post_data", 32'(f_data), 32'd0);
        check("mid_post_empty", 32'(f_empty), 32'd1);
        s_data  = 8'h3C;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        rd_en   = 1'b1;
        tick();
        rd_en = 1'b0;
        check("mid_new_data", 32'(f_data), 32'h3C);
        check("mid_new_empty", 32'(f_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_fifo_rd_bridge.md
Name: stream_fifo_rd_bridge

Overview:
- Single-clock buffer that accepts a valid/ready stream and presents it to a consumer as a standard non-FWFT FIFO read port: rd_en, registered rd_data, empty.
- It is the inverse of the FIFO-to-stream read adapter. Blocks with FIFO-style pop logic (SPI/display/encoder engines) use it to consume stream sources without rewriting their read FSMs.
- Internal storage is 2**AW entries of DW bits.

Parameters:
DW, 8, data width in bits
AW, 4, address width; depth = 2**AW entries

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
stream_s_data_i  input  DW  stream slave data
stream_s_valid_i  input  1  stream slave valid
stream_s_ready_o  output  1  stream slave ready
fifo_rd_en_i  input  1  pop request from consumer
fifo_data_o  output  DW  read data, registered, valid 1 cycle after accepted pop
fifo_empty_o  output  1  no entries available to pop
fifo_level_o  output  AW+1  current entry count, 0..2**AW
fifo_underflow_o  output  1  sticky: pop requested while empty

Behaviour:
- Reset behaviour:
  - Reset is asynchronous and active-low (rst_n). It is applied immediately and released synchronously to clk by the integrator.
  - Under reset: wr_ptr=0, rd_ptr=0, fifo_empty_o=1, fifo_level_o=0, fifo_data_o=0, fifo_underflow_o=0, stream_s_ready_o=0.
  - Memory contents are not reset.
- Pointers:
  - wr_ptr and rd_ptr are AW+1 bits wide and wrap modulo 2**(AW+1).
  - full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]).
  - empty = (wr_ptr == rd_ptr).
  - level = wr_ptr - rd_ptr (AW+1-bit subtraction).
- Write:
  - stream_s_ready_o = !full, registered so that it is 0 while rst_n=0 and in the first cycle after reset release.
  - A beat is accepted when valid && ready. The data is stored at mem[wr_ptr[AW-1:0]] and wr_ptr increments.
  - stream_s_data_i is sampled only on accepted beats.
- Read (non-FWFT):
  - A pop is accepted when fifo_rd_en_i && !fifo_empty_o. On the next rising edge, fifo_data_o <= mem[rd_ptr[AW-1:0]] and rd_ptr increments.
  - Read latency is exactly 1 cycle from the accepted pop to fifo_data_o valid.
  - fifo_data_o holds its value until the next accepted pop.
- Flag timing:
  - fifo_empty_o and fifo_level_o are combinational from the registered pointers. A write becomes visible (empty falls) the cycle after acceptance.
  - There is no write-to-read bypass: minimum write-to-data latency is 2 cycles.
- Underflow:
  - fifo_rd_en_i while fifo_empty_o=1 is ignored: no pointer change, fifo_data_o unchanged.
  - It sets fifo_underflow_o, which stays set until reset.
- Simultaneous events:
  - Write and pop in the same cycle are both accepted; level is unchanged.
  - When full, ready=0 and no write occurs. A pop in that cycle frees one slot, and ready rises the next cycle (no same-cycle pass-through).
  - When empty, a write plus rd_en in the same cycle accepts the write and flags underflow; the pop is not performed.
- Wrap-around: pointers wrap naturally. Data order is preserved across the 2**AW boundary.
- Reset mid-operation: contents are discarded, and all outputs return to their reset values immediately (asynchronously).
- Stream rules: valid/data from the source must be held until ready. This block makes no combinational path from stream_s_valid_i to stream_s_ready_o.

Test Plan:
1. Reset sequencing:
   - Stimulus: hold rst_n=0 for 5 cycles with valid=1, rd_en=1, then release.
   - Required: ready=0 and empty=1 throughout reset and in the first cycle after release; ready=1 in the second cycle; underflow=1 after the first post-reset pop attempt while empty.
2. Ordered transfer:
   - Stimulus: DW=8, AW=4; stream 0x01..0x05 with valid continuous, then pulse rd_en for 5 cycles.
   - Required: fifo_data_o reads 0x01..0x05 in order, each one cycle after its pop; empty=1 after the last pop; level returns to 0.
3. Fill to full:
   - Stimulus: push 16 beats with no pops.
   - Required: level=16 and ready=0; a 17th beat stays pending. After one pop, ready=1 on the next cycle and the 17th beat is accepted; level=16 again.
4. Concurrent streaming and wrap:
   - Stimulus: push and pop every cycle for 40 beats (values 0..39), starting with 3 entries preloaded.
   - Required: level stays at 3; output order is exact across pointer wraps; no underflow.
5. Empty boundary:
   - Stimulus: with the FIFO empty, assert valid(0xA5) and rd_en in the same cycle.
   - Required: write accepted and underflow=1; fifo_data_o unchanged; empty=0 the next cycle; a subsequent pop returns 0xA5.
6. Mid-operation reset:
   - Stimulus: with level=7, drop rst_n mid-cycle.
   - Required: empty=1, level=0, data_o=0 and ready=0 immediately. After release, the old data is never produced.
